// File: rtl/ring_counter_checker.sv
// Ring-counter checker: locks onto a circulating one-hot word, tracks its direction and flags corrupt or illegal steps.
// Optional step counter is built only when RING_STEP_COUNT_EN is defined.
module ring_counter_checker #(
    parameter int word_size = 8,
    parameter int idx_size  = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_sample_enable_n,
    input  logic [word_size-1:0] i_ring,
    output logic [idx_size-1:0]  o_index,
    output logic                 o_dir,
    output logic                 o_locked,
    output logic                 o_onehot_err,
    output logic                 o_step_err,
    output logic [7:0]           o_step_count
);

    typedef enum logic [1:0] {
        HUNT,
        DIR,
        LOCKED
    } state_t;

    localparam logic [idx_size-1:0] LAST_IDX = idx_size'(word_size - 1);

    state_t              state_q, state_d;
    logic [idx_size-1:0] index_q, index_d;
    logic                dir_q, dir_d;
    logic                onehot_err_q, onehot_err_d;
    logic                step_err_q, step_err_d;
    logic                count_clr, count_inc;

    logic                is_onehot;
    logic [idx_size-1:0] sample_idx;
    logic [idx_size-1:0] next_dn, next_up, next_locked;

    // Clearing the lowest set bit leaves zero only for a single-bit word.
    assign is_onehot = (i_ring != '0) && ((i_ring & (i_ring - word_size'(1))) == '0);

    always_comb begin
        sample_idx = '0;
        for (int i = 0; i < word_size; i++) begin
            if (i_ring[i]) sample_idx = idx_size'(i);
        end
    end

    assign next_dn     = (index_q == '0)       ? LAST_IDX : index_q - idx_size'(1);
    assign next_up     = (index_q == LAST_IDX) ? '0       : index_q + idx_size'(1);
    assign next_locked = dir_q ? next_up : next_dn;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d      = state_q;
        index_d      = index_q;
        dir_d        = dir_q;
        onehot_err_d = 1'b0;
        step_err_d   = 1'b0;
        count_clr    = 1'b0;
        count_inc    = 1'b0;

        if (!i_sample_enable_n) begin
            if (!is_onehot) begin
                onehot_err_d = 1'b1;
                state_d      = HUNT;
                count_clr    = 1'b1;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        index_d   = sample_idx;
                        state_d   = DIR;
                        count_clr = 1'b1;
                    end
                    DIR: begin
                        // Down is tested first so a two-bit ring resolves to dir=0.
                        if (sample_idx == next_dn) begin
                            dir_d   = 1'b0;
                            index_d = sample_idx;
                            state_d = LOCKED;
                        end else if (sample_idx == next_up) begin
                            dir_d   = 1'b1;
                            index_d = sample_idx;
                            state_d = LOCKED;
                        end else if (sample_idx != index_q) begin
                            step_err_d = 1'b1;
                            index_d    = sample_idx;
                            count_clr  = 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (sample_idx == next_locked) begin
                            index_d   = sample_idx;
                            count_inc = 1'b1;
                        end else if (sample_idx != index_q) begin
                            step_err_d = 1'b1;
                            index_d    = sample_idx;
                            state_d    = DIR;
                            count_clr  = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = HUNT;
                        count_clr = 1'b1;
                    end
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= HUNT;
            index_q      <= '0;
            dir_q        <= 1'b0;
            onehot_err_q <= 1'b0;
            step_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            dir_q        <= dir_d;
            onehot_err_q <= onehot_err_d;
            step_err_q   <= step_err_d;
        end
    end

`ifdef RING_STEP_COUNT_EN
    logic [7:0] step_count_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            step_count_q <= 8'h00;
        end else if (count_clr) begin
            step_count_q <= 8'h00;
        end else if (count_inc && (step_count_q != 8'hFF)) begin
            step_count_q <= step_count_q + 8'h01;
        end
    end

    assign o_step_count = step_count_q;
`else
    logic unused_count;

    assign unused_count = count_clr ^ count_inc;
    assign o_step_count = 8'h00;
`endif

    assign o_index      = index_q;
    assign o_dir        = dir_q;
    assign o_locked     = (state_q == LOCKED);
    assign o_onehot_err = onehot_err_q;
    assign o_step_err   = step_err_q;

endmodule
